wb_mux_nport: RTL and testbench
===============================

WB_MUX_NPORT -- requirements
Module: wb_mux_nport

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_SLAVES, 4, slave port count, legal range 1..16.
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- TIMEOUT_CYCLES, 255, ACTIVE cycles before a forced error; 0 disables the timeout.
REQ-002 SEL_WIDTH SHALL equal DATA_WIDTH/8, and N SHALL denote NUM_SLAVES.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, sole clock.
- i_rst_n, in, 1, reset, asynchronous, active-low.
- wbm_adr_i, in, ADDR_WIDTH, master address.
- wbm_dat_i, in, DATA_WIDTH, master write data.
- wbm_dat_o, out, DATA_WIDTH, read data to master.
- wbm_we_i / wbm_stb_i / wbm_cyc_i, in, 1 each, master controls.
- wbm_sel_i, in, SEL_WIDTH, byte select.
- wbm_ack_o / wbm_err_o / wbm_rty_o, out, 1 each, responses.
- wbs_adr_o, out, N*ADDR_WIDTH, per-slave address.
- wbs_dat_o, out, N*DATA_WIDTH, per-slave write data.
- wbs_dat_i, in, N*DATA_WIDTH, per-slave read data.
- wbs_sel_o, out, N*SEL_WIDTH, per-slave byte select.
- wbs_we_o / wbs_stb_o / wbs_cyc_o, out, N each, per-slave controls.
- wbs_ack_i / wbs_err_i / wbs_rty_i, in, N each, per-slave responses.
- wbs_addr / wbs_addr_msk, in, N*ADDR_WIDTH each, slave prefix and mask.
- o_err_count, out, 16, saturating count of error responses issued to the master.

Function
REQ-004 FSM states SHALL be IDLE, DECODE, ACTIVE, RESP.
REQ-005 IDLE: on wbm_cyc_i & wbm_stb_i, the block SHALL register adr/dat/we/sel and go to DECODE.
REQ-006 DECODE: slave i SHALL match when (adr & wbs_addr_msk[i]) == (wbs_addr[i] & wbs_addr_msk[i]); on multiple matches the lowest index SHALL win.
REQ-007 DECODE with a match: the block SHALL latch the index and enter ACTIVE, asserting wbs_cyc_o[i] and wbs_stb_o[i] on the next cycle.
REQ-008 DECODE with no match: the block SHALL enter RESP with an error response pending.
REQ-009 ACTIVE drive: only the selected slave SHALL see cyc/stb; every slave's adr/dat/we/sel SHALL carry the registered request.
REQ-010 ACTIVE response: on a selected-slave ack/err/rty, the block SHALL capture wbs_dat_i[i] and the response type, drop the slave's cyc/stb, and enter RESP.
REQ-011 Simultaneous slave responses: err SHALL beat rty, and rty SHALL beat ack.
REQ-012 Timeout counter: SHALL clear on ACTIVE entry and increment each ACTIVE cycle.
REQ-013 Timeout expiry: on reaching TIMEOUT_CYCLES with no response, the block SHALL drop the slave and enter RESP with err; a slave response in the expiry cycle SHALL take precedence.
REQ-014 RESP: exactly one of wbm_ack_o/err_o/rty_o SHALL be high for exactly one cycle, wbm_dat_o SHALL be valid with ack, then the FSM SHALL return to IDLE.
REQ-015 Latency: master request at cycle 0 and slave ack at cycle k SHALL give wbm_ack_o at cycle k+1 (k >= 2); an unmapped address SHALL give wbm_err_o at cycle 2.
REQ-016 Abort: wbm_cyc_i low in DECODE or ACTIVE SHALL drop all slave cyc/stb next cycle, issue no response, and return to IDLE.
REQ-017 o_err_count SHALL increment on every wbm_err_o pulse and saturate at 16'hFFFF.

Reset
REQ-018 On i_rst_n low: FSM SHALL be IDLE, and all wbm_* and wbs_* outputs, o_err_count and the timeout counter SHALL be 0.
REQ-019 Reset mid-transaction SHALL drop slave cyc/stb asynchronously with no response issued.

Structure
REQ-020 Package wb_pkg SHALL hold the FSM state typedef and the default width/timeout constants.
REQ-021 Sub-module wb_addr_decode SHALL be the combinational priority decoder, outputting hit and index.

Verification
REQ-022 N=2, slave0 0x0000_0000/0xFFFF_FF00, slave1 0x0000_0100/0xFFFF_FF00: read 0x104, slave1 acks at k=3 with 0xDEADBEEF -> wbm_ack_o at cycle 4 with wbm_dat_o=0xDEADBEEF; slave0 stb never high.
REQ-023 Write 0x0000_0200 (unmapped) -> wbm_err_o at cycle 2, no slave stb, o_err_count=1.
REQ-024 TIMEOUT_CYCLES=8, silent slave0 -> slave0 cyc drops and wbm_err_o pulses after 8 ACTIVE cycles.
REQ-025 Both slaves given mask 0 (both match) -> slave0 selected; slave asserts ack+err together -> wbm_err_o only.
REQ-026 Master drops cyc in ACTIVE, and separately i_rst_n pulses low in ACTIVE -> slave cyc/stb low, no wbm response, next transaction completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state type, default constants and helpers for the wishbone n-port mux
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RESP   = 2'd3
    } wb_state_t;

    localparam int WB_DEF_NUM_SLAVES = 4;
    localparam int WB_DEF_DATA_WIDTH = 32;
    localparam int WB_DEF_ADDR_WIDTH = 32;
    localparam int WB_DEF_TIMEOUT    = 255;

    // Width of a slave index; a single-slave mux still carries a 1-bit index.
    function automatic int wb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational prefix/mask decoder, lowest matching slave wins
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES = WB_DEF_NUM_SLAVES,
    parameter int ADDR_WIDTH = WB_DEF_ADDR_WIDTH,
    parameter int IDX_W      = wb_idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0]            i_adr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] i_base,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] i_mask,
    output logic                             o_hit,
    output logic [IDX_W-1:0]                 o_idx
);

    // Scan from the highest slave down so the lowest matching index is the last write.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((i_adr & i_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (i_base[i*ADDR_WIDTH +: ADDR_WIDTH] & i_mask[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_nport.sv
// rtl/wb_mux_nport.sv - single-master to N-slave wishbone mux with address decode and timeout
module wb_mux_nport
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES     = WB_DEF_NUM_SLAVES,
    parameter int DATA_WIDTH     = WB_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = WB_DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = WB_DEF_TIMEOUT
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
    output logic [DATA_WIDTH-1:0]            wbm_dat_o,
    input  logic                             wbm_we_i,
    input  logic                             wbm_stb_i,
    input  logic                             wbm_cyc_i,
    input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic                             wbm_rty_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
    output logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]            wbs_we_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]            wbs_err_i,
    input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr_msk,
    output logic [15:0]                      o_err_count
);

    localparam int SEL_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_W      = wb_idx_width(NUM_SLAVES);
    localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);
    localparam bit   TMO_EN   = (TIMEOUT_CYCLES != 0);

    wb_state_t               r_state;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_wdat;
    logic                    r_we;
    logic [SEL_WIDTH-1:0]    r_sel;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_SLAVES-1:0]   r_slv_en;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic                    r_ack;
    logic                    r_err;
    logic                    r_rty;
    logic [DATA_WIDTH-1:0]   r_rdat;
    logic [15:0]             r_err_cnt;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_s_ack;
    logic                    w_s_err;
    logic                    w_s_rty;
    logic [DATA_WIDTH-1:0]   w_s_dat;
    logic                    w_tmo_hit;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .i_adr  (r_adr),
        .i_base (wbs_addr),
        .i_mask (wbs_addr_msk),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_s_ack   = wbs_ack_i[r_idx];
    assign w_s_err   = wbs_err_i[r_idx];
    assign w_s_rty   = wbs_rty_i[r_idx];
    assign w_s_dat   = wbs_dat_i[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);

    // Transaction FSM: capture request, decode, drive one slave, return a single-cycle response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_idx     <= '0;
            r_slv_en  <= '0;
            r_tmo_cnt <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rty     <= 1'b0;
            r_rdat    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_rty <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        r_adr   <= wbm_adr_i;
                        r_wdat  <= wbm_dat_i;
                        r_we    <= wbm_we_i;
                        r_sel   <= wbm_sel_i;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!wbm_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_idx     <= w_idx;
                        r_slv_en  <= NUM_SLAVES'(1) << w_idx;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_ACTIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_ACTIVE: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    // Master abort wins over everything; a real slave answer beats the timeout.
                    if (!wbm_cyc_i) begin
                        r_slv_en <= '0;
                        r_state  <= ST_IDLE;
                    end else if (w_s_err || w_s_rty || w_s_ack) begin
                        r_slv_en <= '0;
                        r_rdat   <= w_s_dat;
                        r_err    <= w_s_err;
                        r_rty    <= !w_s_err && w_s_rty;
                        r_ack    <= !w_s_err && !w_s_rty;
                        r_state  <= ST_RESP;
                    end else if (w_tmo_hit) begin
                        r_slv_en <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_slv_en <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating tally of error responses seen by the master.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (r_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign wbm_dat_o   = r_rdat;
    assign wbm_ack_o   = r_ack;
    assign wbm_err_o   = r_err;
    assign wbm_rty_o   = r_rty;
    assign wbs_cyc_o   = r_slv_en;
    assign wbs_stb_o   = r_slv_en;
    assign wbs_adr_o   = {NUM_SLAVES{r_adr}};
    assign wbs_dat_o   = {NUM_SLAVES{r_wdat}};
    assign wbs_sel_o   = {NUM_SLAVES{r_sel}};
    assign wbs_we_o    = {NUM_SLAVES{r_we}};
    assign o_err_count = r_err_cnt;

endmodule

// File: tb/tb_wb_mux_nport.sv
// tb/tb_wb_mux_nport.sv - scoreboard bench for the two-slave wishbone mux
module tb_wb_mux_nport;

    localparam int NS = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    localparam int RT_ACK = 0;
    localparam int RT_ERR = 1;
    localparam int RT_RTY = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [AW-1:0]     wbm_adr_i = '0;
    logic [DW-1:0]     wbm_dat_i = '0;
    logic [DW-1:0]     wbm_dat_o;
    logic              wbm_we_i = 1'b0;
    logic              wbm_stb_i = 1'b0;
    logic              wbm_cyc_i = 1'b0;
    logic [DW/8-1:0]   wbm_sel_i = '1;
    logic              wbm_ack_o;
    logic              wbm_err_o;
    logic              wbm_rty_o;
    logic [NS*AW-1:0]  wbs_adr_o;
    logic [NS*DW-1:0]  wbs_dat_o;
    logic [NS*DW-1:0]  wbs_dat_i = '0;
    logic [NS*(DW/8)-1:0] wbs_sel_o;
    logic [NS-1:0]     wbs_we_o;
    logic [NS-1:0]     wbs_stb_o;
    logic [NS-1:0]     wbs_cyc_o;
    logic [NS-1:0]     wbs_ack_i = '0;
    logic [NS-1:0]     wbs_err_i = '0;
    logic [NS-1:0]     wbs_rty_i = '0;
    logic [NS*AW-1:0]  wbs_addr = {32'h0000_0100, 32'h0000_0000};
    logic [NS*AW-1:0]  wbs_addr_msk = {32'hFFFF_FF00, 32'hFFFF_FF00};
    logic [15:0]       o_err_count;

    wb_mux_nport #(
        .NUM_SLAVES     (NS),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .wbm_adr_i    (wbm_adr_i),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_we_i     (wbm_we_i),
        .wbm_stb_i    (wbm_stb_i),
        .wbm_cyc_i    (wbm_cyc_i),
        .wbm_sel_i    (wbm_sel_i),
        .wbm_ack_o    (wbm_ack_o),
        .wbm_err_o    (wbm_err_o),
        .wbm_rty_o    (wbm_rty_o),
        .wbs_adr_o    (wbs_adr_o),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_sel_o    (wbs_sel_o),
        .wbs_we_o     (wbs_we_o),
        .wbs_stb_o    (wbs_stb_o),
        .wbs_cyc_o    (wbs_cyc_o),
        .wbs_ack_i    (wbs_ack_i),
        .wbs_err_i    (wbs_err_i),
        .wbs_rty_i    (wbs_rty_i),
        .wbs_addr     (wbs_addr),
        .wbs_addr_msk (wbs_addr_msk),
        .o_err_count  (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          rtype;
        logic [31:0] data;
    } exp_t;

    exp_t      exp_q[$];
    int        n_checks = 0;
    int        n_errors = 0;
    int        cycle_no = 0;
    int        resp_cycle = 0;
    bit        resp_seen = 1'b0;
    logic [NS-1:0] stb_seen = '0;
    int        exp_err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) cycle_no <= cycle_no + 1;

    // Response monitor: every master response must match the head of the scoreboard.
    always @(negedge i_clk) begin
        stb_seen |= wbs_stb_o;
        if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
            exp_t e;
            int   got_t;
            resp_seen  = 1'b1;
            resp_cycle = cycle_no;
            check_val("resp_onehot", 64'($countones({wbm_ack_o, wbm_err_o, wbm_rty_o})), 64'd1);
            got_t = wbm_err_o ? RT_ERR : (wbm_rty_o ? RT_RTY : RT_ACK);
            if (exp_q.size() == 0) begin
                check_val("unexp_resp", 64'(got_t + 1), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("resp_type", 64'(got_t), 64'(e.rtype));
                if (e.rtype == RT_ACK) check_val("resp_data", 64'(wbm_dat_o), 64'(e.data));
            end
        end
    end

    // k < 0 means the slave never answers; rsp is {err, rty, ack} on the selected slave.
    task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                           input int k, input logic [2:0] rsp, input logic [31:0] rdat,
                           input int etype, input int elat, input logic [NS-1:0] estb);
        int  c0;
        int  sidx;
        bit  done;
        exp_t e;
        sidx = estb[1] ? 1 : 0;
        @(posedge i_clk); #1;
        c0 = cycle_no;
        resp_seen = 1'b0;
        stb_seen  = '0;
        wbm_adr_i = adr;
        wbm_we_i  = we;
        wbm_dat_i = ~adr;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbs_dat_i = (sidx == 1) ? {rdat, ~rdat} : {~rdat, rdat};
        e.rtype = etype;
        e.data  = rdat;
        exp_q.push_back(e);
        if (etype == RT_ERR) exp_err_cnt++;
        done = 1'b0;
        for (int t = 1; t <= 40 && !done; t++) begin
            @(posedge i_clk); #1;
            wbs_ack_i = '0;
            wbs_err_i = '0;
            wbs_rty_i = '0;
            if (t == k) begin
                wbs_ack_i[sidx] = rsp[0];
                wbs_rty_i[sidx] = rsp[1];
                wbs_err_i[sidx] = rsp[2];
            end
            if (t == 2) begin
                check_val({tag, "_stb"}, 64'(wbs_stb_o), 64'(estb));
                if (estb != 0) check_val({tag, "_adr"}, 64'(wbs_adr_o[sidx*AW +: AW]), 64'(adr));
            end
            if (estb != 0 && t == elat - 1) check_val({tag, "_cyc_hold"}, 64'(wbs_cyc_o), 64'(estb));
            if (t == elat) check_val({tag, "_cyc_drop"}, 64'(wbs_cyc_o), 64'd0);
            @(negedge i_clk); #1;
            if (resp_seen) done = 1'b1;
        end
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        if (!done) check_val({tag, "_no_resp_timeout"}, 64'd0, 64'd1);
        else check_val({tag, "_latency"}, 64'(resp_cycle - c0), 64'(elat));
        check_val({tag, "_stb_seen"}, 64'(stb_seen), 64'(estb));
        @(posedge i_clk); #1;
        check_val({tag, "_err_cnt"}, 64'(o_err_count), 64'(exp_err_cnt));
    endtask

    // Starts a read to slave1, then at cycle 3 either drops cyc or pulses reset.
    task automatic run_abort(input string tag, input bit use_reset);
        @(posedge i_clk); #1;
        resp_seen = 1'b0;
        wbm_adr_i = 32'h0000_0104;
        wbm_we_i  = 1'b0;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_val({tag, "_stb_on"}, 64'(wbs_stb_o), 64'd2);
        @(posedge i_clk); #1;
        if (!use_reset) begin
            wbm_cyc_i = 1'b0;
            wbm_stb_i = 1'b0;
            @(posedge i_clk); #1;
        end else begin
            i_rst_n = 1'b0;
            #1;
            wbm_cyc_i = 1'b0;
            wbm_stb_i = 1'b0;
            exp_err_cnt = 0;
        end
        check_val({tag, "_slave_off"}, 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
        if (use_reset) begin
            @(posedge i_clk); #1;
            i_rst_n = 1'b1;
        end
        repeat (4) @(posedge i_clk);
        #1;
        check_val({tag, "_no_resp"}, 64'(resp_seen), 64'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_val("rst_resp", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
        check_val("rst_slv_ctl", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 64'd0);
        check_val("rst_slv_adr", 64'(wbs_adr_o), 64'd0);
        check_val("rst_dat_o", 64'(wbm_dat_o), 64'd0);
        check_val("rst_err_cnt", 64'(o_err_count), 64'd0);
        i_rst_n = 1'b1;

        run_txn("rd_s1",     32'h0000_0104, 1'b0, 3,  3'b001, 32'hDEAD_BEEF, RT_ACK, 4,  2'b10);
        run_txn("wr_unmap",  32'h0000_0200, 1'b1, -1, 3'b000, 32'h0,         RT_ERR, 2,  2'b00);
        run_txn("tmo_s0",    32'h0000_0010, 1'b0, -1, 3'b000, 32'h0,         RT_ERR, 10, 2'b01);
        run_txn("wr_s0_k2",  32'h0000_00F0, 1'b1, 2,  3'b001, 32'h1234_5678, RT_ACK, 3,  2'b01);
        run_txn("rty_s1",    32'h0000_01FC, 1'b0, 4,  3'b011, 32'h0BAD_F00D, RT_RTY, 5,  2'b10);
        run_txn("ack_expiry",32'h0000_0020, 1'b0, 9,  3'b001, 32'hA5A5_0001, RT_ACK, 10, 2'b01);

        wbs_addr_msk = '0;
        run_txn("both_match",32'h0000_0104, 1'b0, 2,  3'b101, 32'h5555_AAAA, RT_ERR, 3,  2'b01);
        wbs_addr_msk = {32'hFFFF_FF00, 32'hFFFF_FF00};

        run_abort("abort_cyc", 1'b0);
        run_txn("post_abort",32'h0000_0108, 1'b0, 2,  3'b001, 32'hCAFE_0002, RT_ACK, 3,  2'b10);
        run_abort("abort_rst", 1'b1);
        run_txn("post_rst",  32'h0000_0300, 1'b0, -1, 3'b000, 32'h0,         RT_ERR, 2,  2'b00);
        run_txn("post_rst2", 32'h0000_0004, 1'b1, 5,  3'b001, 32'h0F0F_0F0F, RT_ACK, 6,  2'b01);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
